traffic_junction_ctrl: RTL and testbench

//   Parametrised N-way junction signal controller; generalises the two-road main/country controller.
//   Way 0 is the main road and rests green. Side-road vehicle sensors raise demand.

---
 rtl/traffic_junction_ctrl.sv | 166 ++++++++++++++++
 tb/tb_traffic_junction_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_junction_ctrl.sv
// N-way round-robin junction controller: way 0 rests green, side demand is served with
// min/max green, then yellow and all-red clearance. Define PED_REQ_EN for the pedestrian walk phase.
module traffic_junction_ctrl #(
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned TIMER_W     = 8,
  parameter int unsigned MIN_GREEN   = 8,
  parameter int unsigned MAX_GREEN   = 32,
  parameter int unsigned YELLOW_CYC  = 3,
  parameter int unsigned ALL_RED_CYC = 2,
  parameter int unsigned WALK_CYC    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_WAYS-1:0] demand,
`ifdef PED_REQ_EN
  input  logic                ped_req,
  output logic                walk,
`endif
  output logic [NUM_WAYS-1:0] green,
  output logic [NUM_WAYS-1:0] yellow,
  output logic [NUM_WAYS-1:0] red,
  output logic [2:0]          active_way,
  output logic [1:0]          state
);

  localparam int unsigned WAY_W = 3;

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_ALL_RED = 2'd2,
    ST_WALK    = 2'd3
  } phase_t;

  phase_t              phase_q, phase_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [WAY_W-1:0]    next_q, next_d;
  logic [TIMER_W-1:0]  cnt_q, cnt_d;
  logic [NUM_WAYS-1:0] pend_q, pend_d;
  logic [NUM_WAYS-1:0] way_mask;
  logic [NUM_WAYS-1:0] grant_mask;
  logic                demand_k;
  logic                other;
  logic                grant;
  logic                ped_go;

  // First pending way after k in round-robin order, excluding k; way 0 when none.
  function automatic logic [WAY_W-1:0] rr_search(input logic [WAY_W-1:0] k,
                                                input logic [NUM_WAYS-1:0] p);
    logic [WAY_W-1:0]    r;
    logic                found;
    logic [NUM_WAYS-1:0] sh;
    int unsigned         idx;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 1; i < NUM_WAYS; i++) begin
      idx = (32'(k) + i) % NUM_WAYS;
      sh  = p >> idx;
      if (!found && sh[0]) begin
        r     = WAY_W'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign way_mask   = NUM_WAYS'(1) << way_q;
  assign grant_mask = NUM_WAYS'(1) << next_q;
  assign demand_k   = |(demand & way_mask);
  assign other      = (|(pend_q & ~way_mask)) | (way_q != '0) | ped_go;

`ifdef PED_REQ_EN
  logic ped_q;
  logic walk_entry;

  assign ped_go     = ped_q;
  assign walk_entry = (phase_q == ST_YELLOW) && (phase_d == ST_WALK);

  // Pedestrian request latch; the request is consumed when WALK starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_q <= 1'b0;
    end else if (walk_entry) begin
      ped_q <= 1'b0;
    end else if (ped_req) begin
      ped_q <= 1'b1;
    end
  end
`else
  assign ped_go = 1'b0;
`endif

  // Phase sequencing; next_way is fixed when green ends, applied when all-red ends.
  always_comb begin
    phase_d = phase_q;
    way_d   = way_q;
    next_d  = next_q;
    grant   = 1'b0;
    case (phase_q)
      ST_GREEN: begin
        if ((cnt_q >= TIMER_W'(MIN_GREEN - 1)) && other &&
            (!demand_k || (cnt_q >= TIMER_W'(MAX_GREEN - 1)))) begin
          phase_d = ST_YELLOW;
          next_d  = rr_search(way_q, pend_q);
        end
      end
      ST_YELLOW: begin
        if (cnt_q >= TIMER_W'(YELLOW_CYC - 1)) begin
          phase_d = ped_go ? ST_WALK : ST_ALL_RED;
        end
      end
      ST_WALK: begin
        if (cnt_q >= TIMER_W'(WALK_CYC - 1)) begin
          phase_d = ST_ALL_RED;
        end
      end
      ST_ALL_RED: begin
        if (cnt_q >= TIMER_W'(ALL_RED_CYC - 1)) begin
          phase_d = ST_GREEN;
          way_d   = next_q;
          grant   = 1'b1;
        end
      end
    endcase
  end

  // Phase timer clears on any phase change and saturates at all-ones.
  assign cnt_d = (phase_d != phase_q) ? '0 :
                 (&cnt_q)             ? cnt_q : cnt_q + TIMER_W'(1);

  // The green way's own demand is ignored; demand in the grant cycle is dropped.
  assign pend_d = (pend_q | (demand & ~((phase_q == ST_GREEN) ? way_mask : '0)))
                  & ~(grant ? grant_mask : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= ST_GREEN;
      way_q   <= '0;
      next_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      phase_q <= phase_d;
      way_q   <= way_d;
      next_q  <= next_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Moore lamp decode of the registered phase and way.
  always_comb begin
    green  = '0;
    yellow = '0;
    if (phase_q == ST_GREEN)  green  = way_mask;
    if (phase_q == ST_YELLOW) yellow = way_mask;
    red        = ~(green | yellow);
    active_way = way_q;
    state      = phase_q;
  end

`ifdef PED_REQ_EN
  assign walk = (phase_q == ST_WALK);
`endif

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Bench for traffic_junction_ctrl: directed scenarios, a cycle-level behavioural model
// compared every cycle, and literal expectations on grant order and phase lengths.
`timescale 1ns/1ps
module tb_traffic_junction_ctrl;

  localparam int NW    = 4;
  localparam int TW    = 8;
  localparam int MIN_G = 8;
  localparam int MAX_G = 32;
  localparam int YEL   = 3;
  localparam int AR    = 2;
  localparam int WLK   = 10;

  localparam int P_G = 0;
  localparam int P_Y = 1;
  localparam int P_R = 2;
  localparam int P_W = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NW-1:0] demand = '0;
  logic [NW-1:0] green, yellow, red;
  logic [2:0]    active_way;
  logic [1:0]    state;
`ifdef PED_REQ_EN
  logic          ped_req = 1'b0;
  logic          walk;
`endif

  always #5 clk = ~clk;

  traffic_junction_ctrl #(
    .NUM_WAYS(NW), .TIMER_W(TW), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
    .YELLOW_CYC(YEL), .ALL_RED_CYC(AR), .WALK_CYC(WLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .demand(demand),
`ifdef PED_REQ_EN
    .ped_req(ped_req),
    .walk(walk),
`endif
    .green(green),
    .yellow(yellow),
    .red(red),
    .active_way(active_way),
    .state(state)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  // Behavioural model: phase, owning way, elapsed green cycles, countdown for timed phases.
  int m_phase = 0;
  int m_way   = 0;
  int m_next  = 0;
  int m_age   = 0;
  int m_left  = 0;
  bit m_ped   = 1'b0;
  bit m_pend [NW];

  always @(posedge clk) begin : model
    int old_phase, old_way, granted;
    bit waiting, walk_in;
    if (rst) begin
      m_phase = P_G; m_way = 0; m_next = 0; m_age = 0; m_left = 0; m_ped = 1'b0;
      for (int j = 0; j < NW; j++) m_pend[j] = 1'b0;
    end else begin
      old_phase = m_phase;
      old_way   = m_way;
      granted   = -1;
      walk_in   = 1'b0;
      case (m_phase)
        P_G: begin
          m_age++;
          waiting = (m_way != 0) || m_ped;
          for (int j = 0; j < NW; j++) if (j != m_way && m_pend[j]) waiting = 1'b1;
          if (m_age >= MIN_G && waiting && (!demand[m_way] || m_age >= MAX_G)) begin
            m_next = 0;
            for (int s = NW - 1; s >= 1; s--) if (m_pend[(m_way + s) % NW]) m_next = (m_way + s) % NW;
            m_phase = P_Y;
            m_left  = YEL;
          end
        end
        P_Y: begin
          m_left--;
          if (m_left == 0) begin
            if (m_ped) begin m_phase = P_W; m_left = WLK; walk_in = 1'b1; end
            else begin m_phase = P_R; m_left = AR; end
          end
        end
        P_W: begin
          m_left--;
          if (m_left == 0) begin m_phase = P_R; m_left = AR; end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin m_phase = P_G; m_way = m_next; m_age = 0; granted = m_next; end
        end
      endcase
      for (int j = 0; j < NW; j++) begin
        if (demand[j] && !(old_phase == P_G && j == old_way)) m_pend[j] = 1'b1;
        if (j == granted) m_pend[j] = 1'b0;
      end
`ifdef PED_REQ_EN
      if (walk_in) m_ped = 1'b0;
      else if (ped_req) m_ped = 1'b1;
`endif
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : compare
    logic [NW-1:0] eg, ey, er;
    bit bad;
    if (chk_en) begin
      eg = (m_phase == P_G) ? (NW'(1) << m_way) : '0;
      ey = (m_phase == P_Y) ? (NW'(1) << m_way) : '0;
      er = ~(eg | ey);
      bad = (green !== eg) || (yellow !== ey) || (red !== er) ||
            (active_way !== 3'(m_way)) || (state !== 2'(m_phase));
`ifdef PED_REQ_EN
      if (walk !== (m_phase == P_W)) bad = 1'b1;
`endif
      n_vec++;
      if (bad) begin
        n_miss++;
        $display("FAIL per_cycle t=%0t got g=%b y=%b r=%b way=%0d st=%0d, expected g=%b y=%b r=%b way=%0d st=%0d",
                 $time, green, yellow, red, active_way, state, eg, ey, er, m_way, m_phase);
      end
    end
  end

  // Observation logs taken from the DUT outputs for the literal checks.
  int            grant_log[$];
  int            len_log[$];
  int            run_way = -1;
  int            run_len = 0;
  int            yel_cycles = 0;
  int            nogreen = 0;
  int            walk_cycles = 0;
  logic [NW-1:0] prev_green = '0;

  always @(negedge clk) begin : monitor
    if (green != prev_green) begin
      if (prev_green != '0 && run_way >= 0) len_log.push_back(run_len);
      if (green != '0) begin
        for (int j = 0; j < NW; j++) if (green[j]) run_way = j;
        grant_log.push_back(run_way);
      end
      run_len = 0;
    end
    if (green != '0) run_len++;
    else nogreen++;
    if (yellow != '0) yel_cycles++;
`ifdef PED_REQ_EN
    if (walk) walk_cycles++;
`endif
    prev_green = green;
  end

  task automatic clear_logs();
    grant_log.delete();
    len_log.delete();
    run_way     = -1;
    run_len     = 0;
    yel_cycles  = 0;
    nogreen     = 0;
    walk_cycles = 0;
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic tick(input logic [NW-1:0] d, input logic r, input logic p);
    demand = d;
    rst    = r;
`ifdef PED_REQ_EN
    ped_req = p;
`else
    if (p) demand = d;
`endif
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick('0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick('0, 1'b1, 1'b0);
    clear_logs();
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk_en = 1'b1;

    // 1: idle rest on way 0
    do_reset();
    check_lit("t1_reset_green", int'(green), 1);
    check_lit("t1_reset_red", int'(red), 14);
    idle(200);
    check_lit("t1_green", int'(green), 1);
    check_lit("t1_state", int'(state), 0);
    check_lit("t1_yellow_cycles", yel_cycles, 0);

    // 2: single side pulse
    do_reset();
    idle(20);
    tick(4'b0100, 1'b0, 1'b0);
    idle(30);
    check_lit("t2_grants", grant_log.size(), 2);
    check_lit("t2_grant0", q_at(grant_log, 0), 2);
    check_lit("t2_grant1", q_at(grant_log, 1), 0);
    check_lit("t2_way2_len", q_at(len_log, 0), 8);
    check_lit("t2_yellow_cycles", yel_cycles, 6);
    check_lit("t2_gap_cycles", nogreen, 10);

    // 3: simultaneous side demands
    do_reset();
    idle(20);
    tick(4'b1010, 1'b0, 1'b0);
    idle(60);
    check_lit("t3_grants", grant_log.size(), 3);
    check_lit("t3_grant0", q_at(grant_log, 0), 1);
    check_lit("t3_grant1", q_at(grant_log, 1), 3);
    check_lit("t3_grant2", q_at(grant_log, 2), 0);
    check_lit("t3_way1_len", q_at(len_log, 0), 8);
    check_lit("t3_way3_len", q_at(len_log, 1), 8);

    // 4: held demand capped by max green
    do_reset();
    idle(20);
    tick(4'b1010, 1'b0, 1'b0);
    repeat (49) tick(4'b0010, 1'b0, 1'b0);
    idle(60);
    check_lit("t4_grant0", q_at(grant_log, 0), 1);
    check_lit("t4_grant1", q_at(grant_log, 1), 3);
    check_lit("t4_way1_len", q_at(len_log, 0), 32);
    check_lit("t4_way3_len", q_at(len_log, 1), 8);

    // 5: reset in mid-yellow discards the latched demand
    do_reset();
    idle(20);
    tick(4'b0100, 1'b0, 1'b0);
    idle(2);
    check_lit("t5_mid_yellow_state", int'(state), 1);
    tick('0, 1'b1, 1'b0);
    check_lit("t5_after_rst_green", int'(green), 1);
    check_lit("t5_after_rst_state", int'(state), 0);
    clear_logs();
    idle(40);
    check_lit("t5_no_grants", grant_log.size(), 0);
    check_lit("t5_no_yellow", yel_cycles, 0);

`ifdef PED_REQ_EN
    // 6: pedestrian walk from way 0
    do_reset();
    idle(2);
    tick('0, 1'b0, 1'b1);
    idle(40);
    check_lit("t6_walk_cycles", walk_cycles, 10);
    check_lit("t6_yellow_cycles", yel_cycles, 3);
    check_lit("t6_gap_cycles", nogreen, 15);
    check_lit("t6_regrant", q_at(grant_log, 0), 0);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
